// File: rtl/if_id_pkg.sv
// Shared types and constants for the fetch->decode instruction queue.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package if_id_pkg;

  // Default field widths of a fetch packet.
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  // Canonical no-op (addi x0, x0, 0) shown to decode when no packet is present.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One fetch packet: prediction metadata always travels with its instruction.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] inst;
    logic               pred_taken;
    logic               pred_valid;
  } fetch_pkt_t;

  // Value presented on the decode side while the queue has nothing to offer.
  localparam fetch_pkt_t BUBBLE_PKT = '{
    pc:         '0,
    inst:       NOP_INSTR,
    pred_taken: 1'b0,
    pred_valid: 1'b0
  };

endpackage

// File: rtl/if_id_queue.sv
// DEPTH-entry fetch->decode queue carrying PC, instruction and prediction metadata; flush empties it in one cycle.
// Latency: 1 cycle push-to-head; 0 cycles into an empty queue when IF_ID_QUEUE_BYPASS_EN is defined.
// Backpressure: in_ready = !full (registered occupancy only, no ready-through from out_ready); head held until out_ready.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [INSTR_WIDTH-1:0]     in_inst,
  input  logic                       in_pred_taken,
  input  logic                       in_pred_valid,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [INSTR_WIDTH-1:0]     out_inst,
  output logic                       out_pred_taken,
  output logic                       out_pred_valid,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Same layout as if_id_pkg::fetch_pkt_t, sized by this instance's parameters.
  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] inst;
    logic                   pred_taken;
    logic                   pred_valid;
  } pkt_t;

  localparam pkt_t BUBBLE = '{
    pc:         '0,
    inst:       INSTR_WIDTH'(NOP_INSTR),
    pred_taken: 1'b0,
    pred_valid: 1'b0
  };

  pkt_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  pkt_t             in_pkt;
  pkt_t             head_pkt;
  logic             full;
  logic             empty;
  logic             bypass_act;
  logic             push;
  logic             pop;

  assign in_pkt = '{
    pc:         in_pc,
    inst:       in_inst,
    pred_taken: in_pred_taken,
    pred_valid: in_pred_valid
  };

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign count    = count_q;

`ifdef IF_ID_QUEUE_BYPASS_EN
  // Empty queue: fetch packet goes straight to decode in the same cycle.
  assign bypass_act = empty & in_valid & !flush;
`else
  assign bypass_act = 1'b0;
`endif

  // A bypassed packet that decode takes immediately is never stored.
  assign push = in_valid & in_ready & !flush & !(bypass_act & out_ready);
  // Only stored entries are popped; a bypassed packet never touches rd_ptr.
  assign pop  = !empty & out_ready & !flush;

  // Entry storage: write-only on push; contents are never cleared, flush only resets pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_pkt;
    end
  end

  // Pointer and occupancy bookkeeping; flush outranks push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head selection: stored head, else bypassed input, else bubble.
  always_comb begin
    head_pkt  = BUBBLE;
    out_valid = 1'b0;
    if (!empty) begin
      head_pkt  = mem[rd_ptr];
      out_valid = 1'b1;
    end else if (bypass_act) begin
      head_pkt  = in_pkt;
      out_valid = 1'b1;
    end
  end

  assign out_pc         = head_pkt.pc;
  assign out_inst       = head_pkt.inst;
  assign out_pred_taken = head_pkt.pred_taken;
  assign out_pred_valid = head_pkt.pred_valid;

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised successor to the single-entry IF/ID register. A DEPTH-entry instruction queue between fetch and decode that carries PC, instruction and branch-prediction metadata with valid/ready handshakes on both sides. It decouples fetch from decode stalls, and a flush empties the whole queue in one cycle.

## Interface
- PC_WIDTH, 32, width of the PC field.
- INSTR_WIDTH, 32, width of the instruction field.
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  fetch presents a packet.
- in_ready  out  1  the queue can accept a packet; equals !full.
- in_pc  in  PC_WIDTH  PC of the fetched instruction.
- in_inst  in  INSTR_WIDTH  fetched instruction.
- in_pred_taken  in  1  predictor direction.
- in_pred_valid  in  1  predictor hit.
- out_valid  out  1  head packet is valid for decode.
- out_ready  in  1  decode consumes the head packet this cycle.
- out_pc  out  PC_WIDTH  head PC; 0 when !out_valid.
- out_inst  out  INSTR_WIDTH  head instruction; NOP_INSTR when !out_valid.
- out_pred_taken, out_pred_valid  out  1 each  head metadata; 0 when !out_valid.
- flush  in  1  discard all entries (redirect or mispredict).
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage is a circular array with wr_ptr and rd_ptr of $clog2(DEPTH) bits plus count. Pointers wrap modulo DEPTH naturally.
- push = in_valid & in_ready & !flush. On push, write the packet at wr_ptr, then increment wr_ptr.
- pop = out_valid & out_ready & !flush. On pop, increment rd_ptr.
- count update: +1 on push only; -1 on pop only; unchanged on push and pop together.
- full = (count == DEPTH). empty = (count == 0).
- out_valid = !empty. The head fields are driven combinationally from entry rd_ptr. When the queue is empty, the outputs show the bubble values: pc 0, NOP_INSTR, metadata 0.
- Flush has priority over everything else. The next state is wr_ptr = rd_ptr = 0 and count = 0. A push or pop in the flush cycle is dropped. Entry contents are not cleared.
- When full, in_ready is 0 even if a pop occurs in the same cycle. There is no combinational ready-through path.
- A pop while empty is impossible because out_valid is 0.
- Prediction metadata always travels with its instruction. pred_taken is forwarded unchanged even when pred_valid is 0.

## Timing
- Reset (async assert): pointers 0, count 0, out_valid 0, in_ready 1, outputs at bubble values.
- Latency without bypass: a packet pushed at edge N is visible on out_* during cycle N+1.
- Throughput: one push and one pop per cycle sustained at any occupancy below DEPTH.
- Flush asserted during cycle N: out_valid is 0 in cycle N+1, and a new push is accepted in cycle N+1.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for clk. The first push is accepted on the first edge after rst deasserts.

## Configuration
- IF_ID_QUEUE_BYPASS_EN defined: bypass is active when the queue is empty, in_valid=1 and flush=0.
  - out_valid=1 and out_* is driven combinationally from in_*.
  - If out_ready=1, the packet is consumed. Nothing is written, and count stays 0.
  - If out_ready=0, a normal push occurs.
  - Result: zero-cycle latency when the queue is empty.
- IF_ID_QUEUE_BYPASS_EN undefined: there is no in_*→out_* combinational path, and latency is always 1 cycle.

## Structure
- Shared package if_id_pkg holds:
  - typedef fetch_pkt_t, a packed struct {pc, inst, pred_taken, pred_valid};
  - localparam NOP_INSTR = 32'h0000_0013;
  - the bubble constant for fetch_pkt_t.
- Storage is a fetch_pkt_t array inside the module. No sub-module is needed: pointer and count logic is a single always_ff, and the output mux is a single always_comb.

## Test plan
- Reset: assert rst asynchronously mid-cycle → out_valid=0, in_ready=1, count=0, out_inst=0x00000013 immediately.
- Fill/drain with DEPTH=4, out_ready=0: push PCs 0x100, 0x104, 0x108, 0x10C → count=4, in_ready=0. A fifth push is refused. Then out_ready=1 → PCs come out in order, one per cycle, and count reaches 0.
- Wrap-around: 10 back-to-back pushes with out_ready=1 → count stays at 1 (0 with bypass). The PC sequence out is in order with no loss across the pointer wrap.
- Flush: count=3, then flush together with in_valid (PC 0x200) → next cycle count=0 and out_valid=0; PC 0x200 never appears.
- Full with simultaneous pop: count=4, out_ready=1, in_valid=1 → in_ready=0, count=3 next cycle.
- Bypass (macro defined): empty queue, in_valid=1 with PC 0x300 and pred_taken=1, out_ready=1 → out_pc=0x300 and out_pred_taken=1 in the same cycle, count stays 0.
